chien_t3_serial_search: RTL
===========================

// Module: chien_t3_serial_search
// PURPOSE
//  Serial Chien search for the t=3 BCH(1023) decoder, GF(2^10); sits directly downstream of the mSBS t3 key-equation solver.
//  Takes the deg2/deg3 locator coefficient sets, evaluates sigma at one code position per enabled cycle, MSB-first.
//  Emits one error flag per position, then a done pulse with a decoding-failure verdict (root count != locator degree).
// PARAMETERS
//  GF_LEN    10    field width m; the alpha constants are fixed to the GF(2^10) primitive polynomial of the shared multipliers
//  CODE_LEN  1023  (shortened) code length n; 1 <= n <= 2^GF_LEN-1
//  CNT_W     10    position counter width, ceil(log2(CODE_LEN))
// PORTS
//  clk             in   1       clock, rising edge
//  in_ctr_Arst     in   1       reset, asynchronous, active-high
//  in_ctr_en       in   1       advance enable; low = stall, all state holds
//  in_ctr_start    in   1       load coefficients and begin search; honoured in IDLE only
//  in_deg2_A/B     in   GF_LEN  deg2 coefficients: sigma = B + A*x
//  in_deg3_A/B/C/R in   GF_LEN  deg3 coefficients: sigma = C + B*x + A*x^2 + R*x^3
//  out_busy        out  1       high from the start-accept edge until out_done
//  out_err_vld     out  1       out_err_bit valid for the current position
//  out_err_bit     out  1       1 = position (CODE_LEN-1-idx) is in error
//  out_done        out  1       one-cycle pulse after the last flag
//  out_fail        out  1       failure verdict; valid at out_done, held until the next start
//  out_root_cnt    out  2       roots found, saturating at 3 (CHIEN_EARLY_TERM_EN builds only)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counter=0, coefficient registers=0. Reset mid-search aborts with no out_done.
//  FSM: IDLE -start&en-> SEARCH -last idx&en-> FLUSH -en-> DONE -(1 cyc)-> IDLE. in_ctr_start outside IDLE is ignored.
//  Coefficient select at load: C!=0 -> deg3 set (s0=C, s1=B, s2=A, s3=R), else deg2 set (s0=B, s1=A, s2=s3=0).
//  Degree d = index of the highest nonzero s_k. If all s_k=0, d=0 (error-free): all flags forced 0, out_fail=0.
//  Load: reg_k <= s_k * alpha^(k*(2^GF_LEN-CODE_LEN)), k=1..3; reg_0 <= s_0.
//  Each enabled SEARCH cycle: sum = reg_0^reg_1^reg_2^reg_3; flag = (sum==0)&&(d!=0); reg_k <= reg_k*alpha^k.
//  Evaluation idx=i tests sigma(alpha^-(CODE_LEN-1-i)), i.e. code positions are visited high-order first.
//  Flag is registered: out_err_vld/out_err_bit for idx 0 appear 2 enabled edges after start is accepted.
//  Exactly CODE_LEN valid flags per search; out_err_vld is low on stalled cycles and the flags pause with it.
//  Root counter increments per flag and saturates at 3. out_fail = (roots != d); latched at DONE.
//  out_done fires in DONE, i.e. 1 enabled cycle after the last valid flag. out_busy falls in the same cycle.
//  A start asserted in the out_done cycle is ignored; start is accepted only from IDLE on the next cycle.
//  All GF arithmetic is XOR/constant-multiply; no carries, no width growth.
// CONFIGURATION
//  CHIEN_EARLY_TERM_EN defined: once roots == d (d>0), SEARCH jumps to FLUSH on the next enabled edge.
//   The remaining positions are never emitted, so the flag count is < CODE_LEN; out_fail=0.
//   out_root_cnt is exposed.
//  CHIEN_EARLY_TERM_EN undefined: all CODE_LEN flags are always emitted and out_root_cnt is absent.
// STRUCTURE
//  Shared package bch_t3_pkg:
//   - GF_LEN and CODE_LEN defaults
//   - constants ALPHA_OFS_k = alpha^(k*(2^GF_LEN-CODE_LEN)), k=1..3
//   - FSM state encoding IDLE/SEARCH/FLUSH/DONE
//  Sub-module gf_const_mult_2_10: XOR network, one parameterised instance per constant (alpha^1..3 and the offsets).
//  The top level holds the FSM, the counters, the four evaluation registers and the output registers.
// TESTING
//  1 All syndromes zero (all coefficients 0), start -> 1023 flags all 0, out_done 1025 cycles after start, out_fail=0.
//  2 Single error at pos 5 (S1=a^5, S3=a^15, S5=a^25) -> deg2 set chosen.
//    Exactly one flag, at idx 1017; out_fail=0.
//  3 Errors at positions 0, 100, 1022 -> flags at idx 1022, 922 and 0; out_fail=0.
//    With CHIEN_EARLY_TERM_EN: out_done 1 cycle after idx 1022.
//  4 Deg3 set with a random nonzero C and a polynomial with fewer than 3 roots in the field -> out_fail=1 at out_done.
//  5 Deassert in_ctr_en for 7 cycles during case 2 -> flag still at idx 1017; out_done delayed by 7 cycles.
//  6 Assert in_ctr_Arst at idx 300 -> all outputs 0 asynchronously, no out_done.
//    A new start is then accepted and a clean re-run of case 3 passes.

Source files
------------

// File: rtl/bch_t3_pkg.sv
// bch_t3_pkg: shared field constants, FSM encoding and GF(2^10) helpers for the t=3 BCH(1023) decoder.
// The field is built on the primitive polynomial x^10 + x^3 + 1.
package bch_t3_pkg;

  localparam int GF_LEN_DEFAULT   = 10;
  localparam int CODE_LEN_DEFAULT = 1023;
  localparam int GF_ORDER         = (1 << GF_LEN_DEFAULT) - 1;

  // alpha^10 reduces to alpha^3 + 1, so a carry out of bit 9 folds back in as 10'h009
  localparam logic [9:0] GF_POLY_LOW = 10'h009;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } chienState_e;

  // Multiply a field element by alpha (one shift plus conditional reduction)
  function automatic logic [9:0] gfMulAlpha(input logic [9:0] x);
    return {x[8:0], 1'b0} ^ (x[9] ? GF_POLY_LOW : 10'h000);
  endfunction

  // alpha^e, exponent taken modulo the multiplicative group order
  function automatic logic [9:0] gfAlphaPow(input int e);
    logic [9:0] r;
    r = 10'h001;
    for (int i = 0; i < (e % GF_ORDER); i++) begin
      r = gfMulAlpha(r);
    end
    return r;
  endfunction

  // Column j of the constant-multiply matrix is c*alpha^j
  function automatic logic [9:0][9:0] gfColumns(input logic [9:0] c);
    logic [9:0][9:0] cols;
    cols[0] = c;
    for (int j = 1; j < 10; j++) begin
      cols[j] = gfMulAlpha(cols[j-1]);
    end
    return cols;
  endfunction

  // Start-of-search offsets for the default code length: alpha^(k*(2^m - n))
  localparam int         SHORTEN_DEFAULT = (1 << GF_LEN_DEFAULT) - CODE_LEN_DEFAULT;
  localparam logic [9:0] ALPHA_OFS_1     = gfAlphaPow(1 * SHORTEN_DEFAULT);
  localparam logic [9:0] ALPHA_OFS_2     = gfAlphaPow(2 * SHORTEN_DEFAULT);
  localparam logic [9:0] ALPHA_OFS_3     = gfAlphaPow(3 * SHORTEN_DEFAULT);

endpackage

// File: rtl/gf_const_mult_2_10.sv
// gf_const_mult_2_10: multiply a GF(2^10) element by a fixed constant using a pure XOR network.
module gf_const_mult_2_10
  import bch_t3_pkg::*;
#(
  parameter logic [9:0] MULT_CONST = 10'h001
) (
  input  logic [9:0] a_i,
  output logic [9:0] p_o
);

  localparam logic [9:0][9:0] COLS = gfColumns(MULT_CONST);

  // Each set input bit contributes its precomputed column; the fold collapses to XOR gates
  always_comb begin
    p_o = '0;
    for (int j = 0; j < 10; j++) begin
      p_o = p_o ^ (COLS[j] & {10{a_i[j]}});
    end
  end

endmodule

// File: rtl/chien_t3_serial_search.sv
// chien_t3_serial_search: serial Chien search for the t=3 BCH(1023) decoder over GF(2^10).
// Evaluates the error locator at one code position per enabled cycle, high-order position first,
// emits one error flag per position, then a done pulse with a decoding-failure verdict.
// Optional build macro CHIEN_EARLY_TERM_EN: stop searching once every locator root is found
// and expose the root counter on out_root_cnt.
module chien_t3_serial_search
  import bch_t3_pkg::*;
#(
  parameter int GF_LEN   = GF_LEN_DEFAULT,
  parameter int CODE_LEN = CODE_LEN_DEFAULT,
  parameter int CNT_W    = 10
) (
  input  logic              clk,
  input  logic              in_ctr_Arst,
  input  logic              in_ctr_en,
  input  logic              in_ctr_start,
  input  logic [GF_LEN-1:0] in_deg2_A,
  input  logic [GF_LEN-1:0] in_deg2_B,
  input  logic [GF_LEN-1:0] in_deg3_A,
  input  logic [GF_LEN-1:0] in_deg3_B,
  input  logic [GF_LEN-1:0] in_deg3_C,
  input  logic [GF_LEN-1:0] in_deg3_R,
  output logic              out_busy,
  output logic              out_err_vld,
  output logic              out_err_bit,
  output logic              out_done,
  output logic              out_fail
`ifdef CHIEN_EARLY_TERM_EN
  ,
  output logic [1:0]        out_root_cnt
`endif
);

  // Offsets follow this instance's code length so shortened codes start at the right position
  localparam int                SHORTEN_LEN = (1 << GF_LEN) - CODE_LEN;
  localparam logic [9:0]        OFS_1       = gfAlphaPow(1 * SHORTEN_LEN);
  localparam logic [9:0]        OFS_2       = gfAlphaPow(2 * SHORTEN_LEN);
  localparam logic [9:0]        OFS_3       = gfAlphaPow(3 * SHORTEN_LEN);
  localparam logic [9:0]        ALPHA_1     = gfAlphaPow(1);
  localparam logic [9:0]        ALPHA_2     = gfAlphaPow(2);
  localparam logic [9:0]        ALPHA_3     = gfAlphaPow(3);
  localparam logic [CNT_W-1:0]  LAST_IDX    = CNT_W'(CODE_LEN - 1);

  chienState_e       state_q, state_d;
  logic              startAcc;
  logic              earlyHit;

  logic [GF_LEN-1:0] sel0, sel1, sel2, sel3;
  logic [1:0]        selDeg;
  logic [GF_LEN-1:0] load1, load2, load3;
  logic [GF_LEN-1:0] step1, step2, step3;

  logic [GF_LEN-1:0] eval0_q, eval1_q, eval2_q, eval3_q;
  logic [GF_LEN-1:0] evalSum;
  logic              posIsRoot;
  logic [1:0]        deg_q;
  logic [CNT_W-1:0]  idx_q;
  logic [1:0]        rootCnt_q;

  logic              vld1_q, flag1_q;
  logic              busy_q, errVld_q, errBit_q, done_q, fail_q;

  // Pick the deg3 set whenever its constant term is nonzero, and find the locator degree
  always_comb begin
    if (in_deg3_C != '0) begin
      sel0 = in_deg3_C;
      sel1 = in_deg3_B;
      sel2 = in_deg3_A;
      sel3 = in_deg3_R;
    end else begin
      sel0 = in_deg2_B;
      sel1 = in_deg2_A;
      sel2 = '0;
      sel3 = '0;
    end
    if (sel3 != '0)      selDeg = 2'd3;
    else if (sel2 != '0) selDeg = 2'd2;
    else if (sel1 != '0) selDeg = 2'd1;
    else                 selDeg = 2'd0;
  end

  gf_const_mult_2_10 #(.MULT_CONST(OFS_1))   uLoad1 (.a_i(sel1),    .p_o(load1));
  gf_const_mult_2_10 #(.MULT_CONST(OFS_2))   uLoad2 (.a_i(sel2),    .p_o(load2));
  gf_const_mult_2_10 #(.MULT_CONST(OFS_3))   uLoad3 (.a_i(sel3),    .p_o(load3));
  gf_const_mult_2_10 #(.MULT_CONST(ALPHA_1)) uStep1 (.a_i(eval1_q), .p_o(step1));
  gf_const_mult_2_10 #(.MULT_CONST(ALPHA_2)) uStep2 (.a_i(eval2_q), .p_o(step2));
  gf_const_mult_2_10 #(.MULT_CONST(ALPHA_3)) uStep3 (.a_i(eval3_q), .p_o(step3));

  assign evalSum   = eval0_q ^ eval1_q ^ eval2_q ^ eval3_q;
  assign posIsRoot = (evalSum == '0) && (deg_q != 2'd0);

`ifdef CHIEN_EARLY_TERM_EN
  assign earlyHit     = (deg_q != 2'd0) && (rootCnt_q == deg_q);
  assign out_root_cnt = rootCnt_q;
`else
  assign earlyHit     = 1'b0;
`endif

  // Next-state logic; a start seen while the done pulse is still out belongs to the old run
  always_comb begin
    state_d  = state_q;
    startAcc = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_ctr_en && in_ctr_start && !done_q) begin
          state_d  = SEARCH;
          startAcc = 1'b1;
        end
      end
      SEARCH: begin
        if (in_ctr_en && ((idx_q == LAST_IDX) || earlyHit)) state_d = FLUSH;
      end
      FLUSH: begin
        if (in_ctr_en) state_d = DONE;
      end
      DONE: begin
        if (in_ctr_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge in_ctr_Arst) begin
    if (in_ctr_Arst) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Evaluation registers: load the scaled coefficients at start, then step each term by alpha^k
  always_ff @(posedge clk or posedge in_ctr_Arst) begin
    if (in_ctr_Arst) begin
      eval0_q <= '0;
      eval1_q <= '0;
      eval2_q <= '0;
      eval3_q <= '0;
      deg_q   <= 2'd0;
      idx_q   <= '0;
    end else if (in_ctr_en) begin
      if (startAcc) begin
        eval0_q <= sel0;
        eval1_q <= load1;
        eval2_q <= load2;
        eval3_q <= load3;
        deg_q   <= selDeg;
        idx_q   <= '0;
      end else if (state_q == SEARCH) begin
        eval1_q <= step1;
        eval2_q <= step2;
        eval3_q <= step3;
        idx_q   <= idx_q + CNT_W'(1);
      end
    end
  end

  // First flag stage and root counter; both freeze while the search is stalled
  always_ff @(posedge clk or posedge in_ctr_Arst) begin
    if (in_ctr_Arst) begin
      vld1_q    <= 1'b0;
      flag1_q   <= 1'b0;
      rootCnt_q <= 2'd0;
    end else if (in_ctr_en) begin
      vld1_q  <= (state_q == SEARCH);
      flag1_q <= (state_q == SEARCH) && posIsRoot;
      if (startAcc) begin
        rootCnt_q <= 2'd0;
      end else if ((state_q == SEARCH) && posIsRoot && (rootCnt_q != 2'd3)) begin
        rootCnt_q <= rootCnt_q + 2'd1;
      end
    end
  end

  // Output registers; valid and done are qualified by enable so they never repeat across a stall
  always_ff @(posedge clk or posedge in_ctr_Arst) begin
    if (in_ctr_Arst) begin
      errVld_q <= 1'b0;
      errBit_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      errVld_q <= in_ctr_en && vld1_q;
      errBit_q <= in_ctr_en && vld1_q && flag1_q;
      done_q   <= in_ctr_en && (state_q == DONE);
      if (startAcc) begin
        busy_q <= 1'b1;
        fail_q <= 1'b0;
      end else if (in_ctr_en && (state_q == DONE)) begin
        busy_q <= 1'b0;
        fail_q <= (rootCnt_q != deg_q);
      end
    end
  end

  assign out_busy    = busy_q;
  assign out_err_vld = errVld_q;
  assign out_err_bit = errBit_q;
  assign out_done    = done_q;
  assign out_fail    = fail_q;

endmodule
